card_block_writer: RTL and testbench

Stores one variable-length card record into a 32-word RAM block granted by the block allocator. Sits directly downstream of the allocator: requests a free block, waits for its base address, streams up to 31 payload words into offsets 1..31, then writes the header word at offset 0. Drives the shared 1024x32 card RAM write port.

---
 rtl/card_block_writer_pkg.sv | 51 +++++
 rtl/card_block_writer.sv | 193 +++++++++++++++++++
 tb/tb_card_block_writer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_block_writer_pkg.sv
// ---------------------------------------------------------------------------
// card_block_writer_pkg
// Shared definitions for the card RAM block format. The block writer, the
// block allocator and the record reader all agree on these:
//   - block geometry (32 words, word 0 = header, words 1..31 = payload)
//   - RAM address width and allocator timeout
//   - header bit positions (used flag in bit 31, payload count in [4:0])
//   - writer FSM state encoding
//   - helpers that build header and payload words
// ---------------------------------------------------------------------------
package card_block_writer_pkg;

    localparam int BLOCK_WORDS   = 32;
    localparam int ADDR_W        = 10;
    localparam int ALLOC_TIMEOUT = 64;

    localparam int OFFSET_W = $clog2(BLOCK_WORDS);
    localparam int WAIT_W   = $clog2(ALLOC_TIMEOUT + 1);

    localparam int HDR_USED_BIT  = 31;
    localparam int HDR_COUNT_MSB = 4;
    localparam int HDR_COUNT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        WAIT_ADDR,
        DATA,
        HEADER,
        DONE
    } writer_state_e;

    typedef logic [31:0] card_word_t;
    typedef logic [30:0] payload_t;

    // Header word: used flag set, count in the low bits, everything else zero.
    function automatic card_word_t make_header(input logic [OFFSET_W-1:0] count);
        card_word_t word;
        word = '0;
        word[HDR_USED_BIT] = 1'b1;
        word[HDR_COUNT_MSB:HDR_COUNT_LSB] = count;
        return word;
    endfunction

    // Payload words always carry a clear top bit so they can never be
    // mistaken for a header.
    function automatic card_word_t make_payload(input payload_t data);
        return {1'b0, data};
    endfunction

endpackage

// File: rtl/card_block_writer.sv
// ---------------------------------------------------------------------------
// card_block_writer
// Stores one variable-length card record into a 32-word RAM block obtained
// from the block allocator. Requests a block, waits for its base address,
// streams up to 31 payload words into offsets 1..31 and finally writes the
// header word at offset 0, so a header only ever describes a complete record.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               begin a new record (honoured only when idle)
//   alloc_enable        one-cycle block request to the allocator
//   alloc_found         allocator base address valid
//   alloc_addr          allocator base address (32-word aligned)
//   in_valid/in_data/in_last/in_ready   payload stream, beat = valid & ready
//   ram_address/ram_data/ram_wren       card RAM write port (registered)
//   busy                high whenever not idle
//   done                one-cycle pulse after the header write
//   alloc_fail          one-cycle pulse when the allocator times out
//   overflow            sticky: record truncated at 31 payload words
//   base_addr           base of the most recently granted block
// ---------------------------------------------------------------------------
module card_block_writer
    import card_block_writer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              alloc_enable,
    input  logic              alloc_found,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              in_valid,
    input  logic [30:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              alloc_fail,
    output logic              overflow,
    output logic [ADDR_W-1:0] base_addr
);

    localparam logic [OFFSET_W-1:0] LAST_OFFSET = OFFSET_W'(BLOCK_WORDS - 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(ALLOC_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]   WAIT_SETTLE = WAIT_W'(2);

    writer_state_e       state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0]   base_addr_q, base_addr_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    card_word_t          ram_data_q, ram_data_d;
    logic                ram_wren_q, ram_wren_d;
    logic                alloc_enable_q, alloc_enable_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                alloc_fail_q, alloc_fail_d;
    logic                overflow_q, overflow_d;
    logic                beat;

    // in_ready_q is high exactly while the FSM sits in DATA, so it doubles
    // as the state qualifier for accepting a payload beat.
    assign beat = in_valid & in_ready_q;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        offset_d      = offset_q;
        base_addr_d   = base_addr_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        alloc_fail_d  = 1'b0;
        done_d        = 1'b0;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ALLOC;
                    overflow_d = 1'b0;
                end
            end

            ALLOC: begin
                state_d    = WAIT_ADDR;
                wait_cnt_d = '0;
            end

            // The allocator may still show the found flag from the previous
            // grant for a couple of cycles, so it is only trusted once the
            // wait counter has reached 2.
            WAIT_ADDR: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if ((wait_cnt_q >= WAIT_SETTLE) && alloc_found) begin
                    base_addr_d = alloc_addr;
                    offset_d    = OFFSET_W'(1);
                    state_d     = DATA;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    alloc_fail_d = 1'b1;
                    state_d      = IDLE;
                end
            end

            // The terminating beat leaves offset_q on its own offset, which is
            // then exactly the payload count for the header.
            DATA: begin
                if (beat) begin
                    ram_wren_d    = 1'b1;
                    ram_address_d = base_addr_q + {{(ADDR_W-OFFSET_W){1'b0}}, offset_q};
                    ram_data_d    = make_payload(in_data);
                    if (in_last || (offset_q == LAST_OFFSET)) begin
                        state_d = HEADER;
                        if (!in_last) begin
                            overflow_d = 1'b1;
                        end
                    end else begin
                        offset_d = offset_q + OFFSET_W'(1);
                    end
                end
            end

            HEADER: begin
                ram_wren_d    = 1'b1;
                ram_address_d = base_addr_q;
                ram_data_d    = make_header(offset_q);
                state_d       = DONE;
            end

            // The header write becomes visible during DONE; the done pulse is
            // registered from here so it lands in the cycle after that write.
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        alloc_enable_d = (state_d == ALLOC);
        in_ready_d     = (state_d == DATA);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            offset_q       <= '0;
            base_addr_q    <= '0;
            ram_address_q  <= '0;
            ram_data_q     <= '0;
            ram_wren_q     <= 1'b0;
            alloc_enable_q <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            alloc_fail_q   <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            offset_q       <= offset_d;
            base_addr_q    <= base_addr_d;
            ram_address_q  <= ram_address_d;
            ram_data_q     <= ram_data_d;
            ram_wren_q     <= ram_wren_d;
            alloc_enable_q <= alloc_enable_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            alloc_fail_q   <= alloc_fail_d;
            overflow_q     <= overflow_d;
        end
    end

    assign alloc_enable = alloc_enable_q;
    assign in_ready     = in_ready_q;
    assign ram_address  = ram_address_q;
    assign ram_data     = ram_data_q;
    assign ram_wren     = ram_wren_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign alloc_fail   = alloc_fail_q;
    assign overflow     = overflow_q;
    assign base_addr    = base_addr_q;

endmodule

// File: tb/tb_card_block_writer.sv
// Bench for card_block_writer: an allocator/source driver plus a write monitor.
// Expected RAM contents and timing come from the record rules: payload word i
// lands at base+1+i, the header (bit 31 | count) lands at base last.
module tb_card_block_writer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        allocEnable;
   logic        allocFound = 1'b0;
   logic [9:0]  allocAddr = '0;
   logic        inValid = 1'b0;
   logic [30:0] inData = '0;
   logic        inLast = 1'b0;
   logic        inReady;
   logic [9:0]  ramAddress;
   logic [31:0] ramData;
   logic        ramWren;
   logic        busy;
   logic        done;
   logic        allocFail;
   logic        overflow;
   logic [9:0]  baseAddr;

   card_block_writer dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .alloc_enable(allocEnable),
      .alloc_found (allocFound),
      .alloc_addr  (allocAddr),
      .in_valid    (inValid),
      .in_data     (inData),
      .in_last     (inLast),
      .in_ready    (inReady),
      .ram_address (ramAddress),
      .ram_data    (ramData),
      .ram_wren    (ramWren),
      .busy        (busy),
      .done        (done),
      .alloc_fail  (allocFail),
      .overflow    (overflow),
      .base_addr   (baseAddr)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   int  cyc = 0;
   int  errors = 0;
   int  checks = 0;
   wr_t wrQ[$];
   int  allocEnCnt = 0;
   int  allocEnCyc = 0;
   int  doneCnt = 0;
   int  doneCyc = 0;
   int  allocFailCnt = 0;
   int  allocFailCyc = 0;

   // Cycle counter so that write and pulse timing can be compared as numbers.
   always @(posedge clock) cyc <= cyc + 1;

   // Monitor samples the registered outputs just after each rising edge.
   always @(posedge clock) begin
      wr_t w;
      #1;
      if (ramWren) begin
         w.addr = ramAddress;
         w.data = ramData;
         w.cyc  = cyc;
         wrQ.push_back(w);
      end
      if (allocEnable) begin
         allocEnCnt++;
         allocEnCyc = cyc;
      end
      if (done) begin
         doneCnt++;
         doneCyc = cyc;
      end
      if (allocFail) begin
         allocFailCnt++;
         allocFailCyc = cyc;
      end
   end

   // Every comparison funnels through here so the counts stay consistent.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearMonitor();
      wrQ.delete();
      allocEnCnt   = 0;
      doneCnt      = 0;
      allocFailCnt = 0;
   endtask

   // Runs one record: start, allocator grant on wait cycle d (stale flag shown
   // on wait cycles 0 and 1), n payload beats, then checks every RAM write,
   // the header, pulse timing and the overflow flag against the record rules.
   task automatic applyStimulus(input logic [9:0] base, input int d, input int n,
                                input bit useLast, input bit gap, input bit pokeStart,
                                input string tag);
      logic [30:0] words[$];
      logic [30:0] w;
      int          s;
      int          step;
      int          firstCyc;
      int          hdrCyc;
      bit          expOvf;
      clearMonitor();
      step   = gap ? 2 : 1;
      expOvf = (!useLast && n == 31);
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      checkOutput({tag, " alloc_enable"}, 64'(allocEnCnt), 64'd1);
      checkOutput({tag, " busy"}, 64'(busy), 64'd1);
      s = allocEnCyc;
      for (int i = 0; i < d; i++) begin
         @(negedge clock);
         if (i < 2) begin
            allocFound = 1'b1;
            allocAddr  = base ^ 10'h3E0;
         end else begin
            allocFound = 1'b0;
         end
      end
      @(negedge clock);
      allocFound = 1'b1;
      allocAddr  = base;
      @(negedge clock);
      allocFound = 1'b0;
      allocAddr  = 10'($urandom);
      checkOutput({tag, " in_ready up"}, 64'(inReady), 64'd1);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            @(negedge clock);
            if (gap) begin
               inValid = 1'b0;
               if (pokeStart && i == 2) start = 1'b1;
               @(negedge clock);
               start = 1'b0;
            end
         end
         w = 31'($urandom);
         words.push_back(w);
         inValid = 1'b1;
         inData  = w;
         inLast  = useLast && (i == n - 1);
      end
      @(negedge clock);
      inData = 31'($urandom);
      inLast = 1'b0;
      checkOutput({tag, " in_ready drop"}, 64'(inReady), 64'd0);
      @(negedge clock);
      inValid = 1'b0;
      for (int k = 0; k < 12 && doneCnt == 0; k++) @(negedge clock);
      checkOutput({tag, " done count"}, 64'(doneCnt), 64'd1);
      checkOutput({tag, " write count"}, 64'(wrQ.size()), 64'(n + 1));
      firstCyc = s + d + 3;
      for (int i = 0; i < n && i < wrQ.size(); i++) begin
         checkOutput($sformatf("%s pay%0d addr", tag, i), 64'(wrQ[i].addr), 64'(10'(base + 10'(i + 1))));
         checkOutput($sformatf("%s pay%0d data", tag, i), 64'(wrQ[i].data), 64'({1'b0, words[i]}));
         checkOutput($sformatf("%s pay%0d cyc", tag, i), 64'(wrQ[i].cyc), 64'(firstCyc + i * step));
      end
      hdrCyc = firstCyc + (n - 1) * step + 1;
      if (wrQ.size() > n) begin
         checkOutput({tag, " hdr addr"}, 64'(wrQ[n].addr), 64'(base));
         checkOutput({tag, " hdr data"}, 64'(wrQ[n].data), 64'(32'h8000_0000 + 32'(n)));
         checkOutput({tag, " hdr cyc"}, 64'(wrQ[n].cyc), 64'(hdrCyc));
      end
      checkOutput({tag, " done cyc"}, 64'(doneCyc), 64'(hdrCyc + 1));
      checkOutput({tag, " overflow"}, 64'(overflow), 64'(expOvf));
      checkOutput({tag, " base_addr"}, 64'(baseAddr), 64'(base));
      checkOutput({tag, " idle busy"}, 64'(busy), 64'd0);
      checkOutput({tag, " single alloc"}, 64'(allocEnCnt), 64'd1);
   endtask

   // Global guard so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [9:0] b;
      int         n;
      int         s;
      bit         useLast;

      // Power-on reset: every output must be zero.
      repeat (3) @(negedge clock);
      checkOutput("reset ctrl", 64'({allocEnable, inReady, ramWren, busy, done, allocFail, overflow}), 64'd0);
      checkOutput("reset addr", 64'({ramAddress, baseAddr}), 64'd0);
      checkOutput("reset data", 64'(ramData), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Basic three-word record into block 0x040.
      applyStimulus(10'h040, 2, 3, 1'b1, 1'b0, 1'b0, "basic");

      // 31 words without in_last: truncated, overflow set.
      applyStimulus(10'h040, 2, 31, 1'b0, 1'b0, 1'b0, "ovf");

      // Next record clears overflow and waits a little longer for the grant.
      applyStimulus(10'h3E0, 4, 2, 1'b1, 1'b0, 1'b0, "after_ovf");

      // Allocator never answers: alloc_fail after 64 wait cycles, no writes.
      clearMonitor();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      allocFound = 1'b0;
      s = allocEnCyc;
      for (int k = 0; k < 100 && allocFailCnt == 0; k++) @(negedge clock);
      checkOutput("timeout pulse", 64'(allocFailCnt), 64'd1);
      checkOutput("timeout cyc", 64'(allocFailCyc - s), 64'd65);
      checkOutput("timeout busy", 64'(busy), 64'd0);
      @(negedge clock);
      checkOutput("timeout pulse width", 64'(allocFail), 64'd0);
      checkOutput("timeout writes", 64'(wrQ.size()), 64'd0);

      // Beats every other cycle, with a start poke mid-record that must be ignored.
      applyStimulus(10'h1C0, 3, 4, 1'b1, 1'b1, 1'b1, "gap");

      // Reset after the second beat: outputs clear, no header ever appears.
      clearMonitor();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
      repeat (2) @(negedge clock);
      @(negedge clock) begin allocFound = 1'b1; allocAddr = 10'h2A0; end
      @(negedge clock) begin
         allocFound = 1'b0;
         inValid = 1'b1; inData = 31'h1234_5678; inLast = 1'b0;
      end
      @(negedge clock) inData = 31'h0ABC_DEF0;
      @(negedge clock) begin inValid = 1'b0; reset = 1'b1; end
      @(negedge clock);
      checkOutput("midreset ctrl", 64'({allocEnable, inReady, ramWren, busy, done, allocFail, overflow}), 64'd0);
      checkOutput("midreset addr", 64'({ramAddress, baseAddr}), 64'd0);
      checkOutput("midreset data", 64'(ramData), 64'd0);
      reset = 1'b0;
      repeat (6) @(negedge clock);
      checkOutput("midreset writes", 64'(wrQ.size()), 64'd2);
      checkOutput("midreset done", 64'(doneCnt), 64'd0);

      // A full record straight after the mid-record reset.
      applyStimulus(10'h100, 2, 5, 1'b1, 1'b0, 1'b0, "post_reset");

      // Randomized records.
      for (int r = 0; r < 5; r++) begin
         b = 10'($urandom_range(0, 31)) << 5;
         n = $urandom_range(1, 31);
         useLast = (n < 31) ? 1'b1 : 1'($urandom_range(0, 1));
         applyStimulus(b, $urandom_range(2, 6), n, useLast, 1'($urandom_range(0, 1)), 1'b0,
                       $sformatf("rand%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
